// File: rtl/alu_16.sv
// Registered 16-bit ALU: eight ops picked by a 3-bit opcode, one-cycle latency.
// Bitwise ops run in per-bit lanes; arithmetic and shifts are resolved at full width.

module alu_16_lane (
    input  logic       a_i,
    input  logic       b_i,
    input  logic [2:0] op_i,
    output logic       y_o
);
    always_comb begin
        y_o = 1'b0;
        case (op_i)
            3'b010:  y_o = a_i & b_i;
            3'b011:  y_o = a_i | b_i;
            3'b100:  y_o = a_i ^ b_i;
            3'b101:  y_o = ~a_i;
            default: y_o = 1'b0;
        endcase
    end
endmodule

module alu_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] c;
        logic             zero;
        logic             negative;
        logic             carry;
        logic             overflow;
    } alu_rsp_t;

    op_e              op;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] lane_y;
    logic [WIDTH:0]   sum17;
    logic [WIDTH:0]   diff17;
    logic [WIDTH:0]   shl17;
    logic [WIDTH:0]   shr17;
    alu_rsp_t         rsp_d;
    alu_rsp_t         rsp_q;

    assign op = op_e'(control);
    assign sh = b[SHW-1:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        alu_16_lane u_lane (
            .a_i  (a[i]),
            .b_i  (b[i]),
            .op_i (control),
            .y_o  (lane_y[i])
        );
    end

    // Extra bit on each side of the shifters catches the last bit shifted out;
    // a shift of zero leaves that bit at 0, so carry clears without a special case.
    always_comb begin
        rsp_d  = '0;
        sum17  = {1'b0, a} + {1'b0, b};
        diff17 = {1'b0, a} - {1'b0, b};
        shl17  = {1'b0, a} << sh;
        shr17  = {a, 1'b0} >> sh;
        case (op)
            OP_ADD: begin
                rsp_d.c        = sum17[WIDTH-1:0];
                rsp_d.carry    = sum17[WIDTH];
                rsp_d.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum17[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                rsp_d.c        = diff17[WIDTH-1:0];
                rsp_d.carry    = diff17[WIDTH];
                rsp_d.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff17[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL: begin
                rsp_d.c     = shl17[WIDTH-1:0];
                rsp_d.carry = shl17[WIDTH];
            end
            OP_SRL: begin
                rsp_d.c     = shr17[WIDTH:1];
                rsp_d.carry = shr17[0];
            end
            default: rsp_d.c = lane_y;
        endcase
        rsp_d.zero     = (rsp_d.c == '0);
        rsp_d.negative = rsp_d.c[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rsp_q <= '0;
        else     rsp_q <= rsp_d;
    end

    assign c        = rsp_q.c;
    assign zero     = rsp_q.zero;
    assign negative = rsp_q.negative;
    assign carry    = rsp_q.carry;
    assign overflow = rsp_q.overflow;
endmodule

// File: tb/tb_alu_16.sv
// Directed bench for alu_16: reset, each op group, boundary cases, back-to-back issue.

module tb_alu_16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  control = '0;
    logic [15:0] c;
    logic        zero, negative, carry, overflow;

    int nvec  = 0;
    int nfail = 0;

    alu_16 #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .control  (control),
        .c        (c),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // observed bundle {c, zero, negative, carry, overflow}
    function automatic logic [19:0] obs();
        return {c, zero, negative, carry, overflow};
    endfunction

    // drive at negedge, sample 1 ns after the following rising edge
    task automatic apply(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] op);
        @(negedge clk);
        a = av; b = bv; control = op;
        @(posedge clk);
        #1;
    endtask

    // independent reference: integer arithmetic and bit-serial shifting
    function automatic logic [19:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic [2:0] op);
        logic [15:0] r;
        logic        cy, v;
        int          s, sa, sb;
        r = '0; cy = 1'b0; v = 1'b0;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        case (op)
            3'd0: begin
                s = int'(av) + int'(bv); r = s[15:0]; cy = (s > 65535);
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            3'd1: begin
                s = int'(av) - int'(bv); r = s[15:0]; cy = (av < bv);
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            3'd2: r = av & bv;
            3'd3: r = av | bv;
            3'd4: r = av ^ bv;
            3'd5: r = ~av;
            3'd6: begin
                r = av;
                for (int k = 0; k < int'(bv[3:0]); k++) begin cy = r[15]; r = {r[14:0], 1'b0}; end
            end
            default: begin
                r = av;
                for (int k = 0; k < int'(bv[3:0]); k++) begin cy = r[0]; r = {1'b0, r[15:1]}; end
            end
        endcase
        return {r, (r == 16'h0), r[15], cy, v};
    endfunction

    task automatic test_reset();
        // still in power-on reset
        #1;
        nvec++;
        if (obs() !== 20'h0) begin
            nfail++; $display("FAIL reset_initial got=%h want=%h", obs(), 20'h0);
        end
        @(negedge clk) rst = 1'b0;
        apply(16'h1234, 16'h0001, 3'd0);
        nvec++;
        if (obs() !== {16'h1235, 4'b0000}) begin
            nfail++; $display("FAIL reset_preload got=%h want=%h", obs(), {16'h1235, 4'b0000});
        end
        // assert mid-cycle: outputs clear without a clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (obs() !== 20'h0) begin
            nfail++; $display("FAIL reset_async got=%h want=%h", obs(), 20'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (obs() !== 20'h0) begin
            nfail++; $display("FAIL reset_hold got=%h want=%h", obs(), 20'h0);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_add();
        apply(16'h0000, 16'h0010, 3'd0);
        nvec++;
        if (obs() !== {16'h0010, 4'b0000}) begin
            nfail++; $display("FAIL add_basic got=%h want=%h", obs(), {16'h0010, 4'b0000});
        end
        apply(16'h7FFF, 16'h0001, 3'd0);
        nvec++;
        if (obs() !== {16'h8000, 4'b0101}) begin
            nfail++; $display("FAIL add_ovf got=%h want=%h", obs(), {16'h8000, 4'b0101});
        end
        apply(16'hFFFF, 16'h0001, 3'd0);
        nvec++;
        if (obs() !== {16'h0000, 4'b1010}) begin
            nfail++; $display("FAIL add_wrap got=%h want=%h", obs(), {16'h0000, 4'b1010});
        end
    endtask

    task automatic test_sub();
        apply(16'h0010, 16'h0000, 3'd1);
        nvec++;
        if (obs() !== {16'h0010, 4'b0000}) begin
            nfail++; $display("FAIL sub_basic got=%h want=%h", obs(), {16'h0010, 4'b0000});
        end
        apply(16'h0000, 16'h0001, 3'd1);
        nvec++;
        if (obs() !== {16'hFFFF, 4'b0110}) begin
            nfail++; $display("FAIL sub_borrow got=%h want=%h", obs(), {16'hFFFF, 4'b0110});
        end
        apply(16'h8000, 16'h0001, 3'd1);
        nvec++;
        if (obs() !== {16'h7FFF, 4'b0001}) begin
            nfail++; $display("FAIL sub_ovf got=%h want=%h", obs(), {16'h7FFF, 4'b0001});
        end
    endtask

    task automatic test_logic();
        apply(16'h0000, 16'h0010, 3'd2);
        nvec++;
        if (obs() !== {16'h0000, 4'b1000}) begin
            nfail++; $display("FAIL and_zero got=%h want=%h", obs(), {16'h0000, 4'b1000});
        end
        apply(16'h0F0F, 16'hF000, 3'd3);
        nvec++;
        if (obs() !== {16'hFF0F, 4'b0100}) begin
            nfail++; $display("FAIL or got=%h want=%h", obs(), {16'hFF0F, 4'b0100});
        end
        apply(16'hAAAA, 16'hFFFF, 3'd4);
        nvec++;
        if (obs() !== {16'h5555, 4'b0000}) begin
            nfail++; $display("FAIL xor got=%h want=%h", obs(), {16'h5555, 4'b0000});
        end
        apply(16'h00FF, 16'h1234, 3'd5);
        nvec++;
        if (obs() !== {16'hFF00, 4'b0100}) begin
            nfail++; $display("FAIL not got=%h want=%h", obs(), {16'hFF00, 4'b0100});
        end
    endtask

    task automatic test_shift();
        apply(16'h8001, 16'h0001, 3'd6);
        nvec++;
        if (obs() !== {16'h0002, 4'b0010}) begin
            nfail++; $display("FAIL sll1 got=%h want=%h", obs(), {16'h0002, 4'b0010});
        end
        apply(16'h8001, 16'h0001, 3'd7);
        nvec++;
        if (obs() !== {16'h4000, 4'b0010}) begin
            nfail++; $display("FAIL srl1 got=%h want=%h", obs(), {16'h4000, 4'b0010});
        end
        apply(16'h8001, 16'h0010, 3'd6);
        nvec++;
        if (obs() !== {16'h8001, 4'b0100}) begin
            nfail++; $display("FAIL sll0 got=%h want=%h", obs(), {16'h8001, 4'b0100});
        end
        apply(16'h1238, 16'hFFF4, 3'd7);
        nvec++;
        if (obs() !== {16'h0123, 4'b0010}) begin
            nfail++; $display("FAIL srl4_hib got=%h want=%h", obs(), {16'h0123, 4'b0010});
        end
        apply(16'h0003, 16'h000F, 3'd6);
        nvec++;
        if (obs() !== {16'h8000, 4'b0110}) begin
            nfail++; $display("FAIL sll15 got=%h want=%h", obs(), {16'h8000, 4'b0110});
        end
        apply(16'h8000, 16'h000F, 3'd7);
        nvec++;
        if (obs() !== {16'h0001, 4'b0000}) begin
            nfail++; $display("FAIL srl15 got=%h want=%h", obs(), {16'h0001, 4'b0000});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [8] = '{16'h1234, 16'h0005, 16'hF0F0, 16'h0001,
                                16'h1234, 16'h8000, 16'h0000, 16'h8000};
        logic [15:0] vb [8] = '{16'h4321, 16'h0007, 16'hFF00, 16'h0004,
                                16'h1234, 16'h000F, 16'h0000, 16'h8000};
        logic [2:0]  vo [8] = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd4, 3'd7, 3'd5, 3'd0};
        logic [19:0] prev;
        logic [19:0] exp;
        prev = obs();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; control = vo[i];
            #1;
            // before the edge the previous result must still be held
            nvec++;
            if (obs() !== prev) begin
                nfail++; $display("FAIL b2b_hold[%0d] got=%h want=%h", i, obs(), prev);
            end
            @(posedge clk);
            #1;
            exp = model(va[i], vb[i], vo[i]);
            nvec++;
            if (obs() !== exp) begin
                nfail++; $display("FAIL b2b[%0d] got=%h want=%h", i, obs(), exp);
            end
            prev = exp;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
